// File: rtl/seg7_pkg.sv
// Seven-segment glyph codes (g..a, active-high) shared by driver and receiver,
// plus the receive-side frame FSM state type.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'b0111111;
    localparam logic [6:0] SEG_1     = 7'b0000110;
    localparam logic [6:0] SEG_2     = 7'b1011011;
    localparam logic [6:0] SEG_3     = 7'b1001111;
    localparam logic [6:0] SEG_4     = 7'b1100110;
    localparam logic [6:0] SEG_5     = 7'b1101101;
    localparam logic [6:0] SEG_6     = 7'b1111100;
    localparam logic [6:0] SEG_7     = 7'b0000111;
    localparam logic [6:0] SEG_8     = 7'b1111111;
    localparam logic [6:0] SEG_9     = 7'b1100111;
    localparam logic [6:0] SEG_BLANK = 7'b0000000;

    typedef enum logic {
        S_WAIT_U = 1'b0,
        S_WAIT_T = 1'b1
    } state_t;

endpackage

// File: rtl/seven_segment_decoder_if.sv
// Display pins plus the decoded readback; master drives the pins, slave decodes.
interface seven_segment_decoder_if;

    logic [6:0] segments;
    logic       digit;
    logic [3:0] ten_count;
    logic [3:0] unit_count;
    logic       valid;
    logic       changed;
    logic       code_error;
    logic       stalled;

    modport master (
        output segments, digit,
        input  ten_count, unit_count, valid, changed, code_error, stalled
    );

    modport slave (
        input  segments, digit,
        output ten_count, unit_count, valid, changed, code_error, stalled
    );

endinterface

// File: rtl/seg7_glyph_decode.sv
// Purpose: exact-match decode of one seven-segment glyph to BCD with a legality flag.
// Latency: combinational.
// Backpressure: none.
module seg7_glyph_decode
    import seg7_pkg::*;
(
    input  logic [6:0] glyph,
    output logic       legal,
    output logic [3:0] bcd
);

    always_comb begin
        legal = 1'b1;
        bcd   = 4'd0;
        case (glyph)
            SEG_0:   bcd = 4'd0;
            SEG_1:   bcd = 4'd1;
            SEG_2:   bcd = 4'd2;
            SEG_3:   bcd = 4'd3;
            SEG_4:   bcd = 4'd4;
            SEG_5:   bcd = 4'd5;
            SEG_6:   bcd = 4'd6;
            SEG_7:   bcd = 4'd7;
            SEG_8:   bcd = 4'd8;
            SEG_9:   bcd = 4'd9;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seven_segment_decoder.sv
// Purpose: read back a multiplexed 2-digit seven-segment display as a tens/units BCD pair.
// Latency: glyph at pins in cycle t -> valid in cycle t+SYNC_STAGES+STABLE_CYCLES.
// Backpressure: none; pins are sampled every cycle and results are pulses/levels.
module seven_segment_decoder
    import seg7_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seven_segment_decoder_if.slave  bus
);

    localparam logic [3:0]  STABLE_N  = 4'(STABLE_CYCLES);
    localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT_CYCLES);

    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]  synced;
    logic [7:0]  prev_q;
    logic [3:0]  run_q;
    logic [3:0]  run_d;
    logic        accept;
    logic        toggle;
    logic [15:0] stall_q;

    logic        legal;
    logic [3:0]  bcd;

    state_t      state_q;
    state_t      state_d;
    logic [3:0]  units_q;
    logic [3:0]  units_d;
    logic        publish;
    logic        bad_code;

    logic [3:0]  ten_q;
    logic [3:0]  unit_q;
    logic        valid_q;
    logic        changed_q;
    logic        code_error_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= {bus.digit, bus.segments};
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign synced = sync_q[SYNC_STAGES-1];
    assign toggle = synced[7] ^ prev_q[7];

    // Any change, including a digit flip with identical segments, restarts the run.
    always_comb begin
        if (synced != prev_q) begin
            run_d = 4'd1;
        end else if (run_q == 4'hF) begin
            run_d = run_q;
        end else begin
            run_d = run_q + 4'd1;
        end
    end

    assign accept = (run_d == STABLE_N);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q  <= '0;
            run_q   <= '0;
            stall_q <= '0;
        end else begin
            prev_q <= synced;
            run_q  <= run_d;
            if (toggle) begin
                stall_q <= '0;
            end else if (stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    seg7_glyph_decode u_decode (
        .glyph (synced[6:0]),
        .legal (legal),
        .bcd   (bcd)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_WAIT_U;
            units_q <= '0;
        end else begin
            state_q <= state_d;
            units_q <= units_d;
        end
    end

    // An illegal glyph aborts the frame whichever digit carried it.
    always_comb begin
        state_d  = state_q;
        units_d  = units_q;
        publish  = 1'b0;
        bad_code = 1'b0;
        if (accept) begin
            if (!legal) begin
                bad_code = 1'b1;
                units_d  = '0;
                state_d  = S_WAIT_U;
            end else begin
                case (state_q)
                    S_WAIT_U: begin
                        if (!synced[7]) begin
                            units_d = bcd;
                            state_d = S_WAIT_T;
                        end
                    end
                    S_WAIT_T: begin
                        if (synced[7]) begin
                            publish = 1'b1;
                            state_d = S_WAIT_U;
                        end else begin
                            units_d = bcd;
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ten_q        <= '0;
            unit_q       <= '0;
            valid_q      <= 1'b0;
            changed_q    <= 1'b0;
            code_error_q <= 1'b0;
        end else begin
            valid_q      <= publish;
            code_error_q <= bad_code;
            changed_q    <= publish && ({bcd, units_q} != {ten_q, unit_q});
            if (publish) begin
                ten_q  <= bcd;
                unit_q <= units_q;
            end
        end
    end

    assign bus.ten_count  = ten_q;
    assign bus.unit_count = unit_q;
    assign bus.valid      = valid_q;
    assign bus.changed    = changed_q;
    assign bus.code_error = code_error_q;
    assign bus.stalled    = (stall_q >= TIMEOUT_N);

endmodule

// File: tb/tb_seven_segment_decoder.sv
// Bench for seven_segment_decoder: default instance plus a STABLE_CYCLES=3 instance.
module tb_seven_segment_decoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    seven_segment_decoder_if if1 ();
    seven_segment_decoder_if if2 ();

    logic [6:0] seg1 = '0;
    logic       dig1 = 1'b0;
    logic [6:0] seg2 = '0;
    logic       dig2 = 1'b0;

    assign if1.segments = seg1;
    assign if1.digit    = dig1;
    assign if2.segments = seg2;
    assign if2.digit    = dig2;

    seven_segment_decoder dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if1.slave)
    );

    seven_segment_decoder #(
        .SYNC_STAGES    (2),
        .STABLE_CYCLES  (3),
        .TIMEOUT_CYCLES (1024)
    ) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if2.slave)
    );

    localparam logic [6:0] G0 = 7'b0111111;
    localparam logic [6:0] G1 = 7'b0000110;
    localparam logic [6:0] G2 = 7'b1011011;
    localparam logic [6:0] G3 = 7'b1001111;
    localparam logic [6:0] G4 = 7'b1100110;
    localparam logic [6:0] G5 = 7'b1101101;
    localparam logic [6:0] G6 = 7'b1111100;
    localparam logic [6:0] G7 = 7'b0000111;
    localparam logic [6:0] G8 = 7'b1111111;
    localparam logic [6:0] G9 = 7'b1100111;
    localparam logic [6:0] GX = 7'b1010101;
    localparam logic [6:0] GB = 7'b0000000;

    typedef struct packed {
        logic [3:0] ten;
        logic [3:0] unit;
        logic       chg;
    } exp_t;

    typedef struct {
        logic [6:0] u_seg;
        logic [6:0] t_seg;
        logic [3:0] ten;
        logic [3:0] unit;
        logic       chg;
        logic       ok;
    } vec_t;

    exp_t q1[$];
    int total = 0;
    int bad = 0;
    int v1_cnt = 0;
    int v2_cnt = 0;
    int e1_cnt = 0;
    int e1_cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every valid on dut1 must match the oldest expected pair.
    always @(negedge clk) begin
        if (rst_n && if1.valid) begin
            v1_cnt++;
            if (q1.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got %0d/%0d expected no publish",
                         if1.ten_count, if1.unit_count);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("pair", 32'({if1.ten_count, if1.unit_count, if1.changed}),
                      32'({e.ten, e.unit, e.chg}));
            end
        end
        if (rst_n && if1.code_error) begin
            e1_cnt++;
            e1_cyc = cyc;
        end
        if (rst_n && if2.valid) v2_cnt++;
    end

    task automatic d1(input logic [6:0] s, input logic d);
        seg1 = s;
        dig1 = d;
        @(posedge clk);
        #1;
    endtask

    task automatic d2(input logic [6:0] s, input logic d, input int n);
        seg2 = s;
        dig2 = d;
        repeat (n) @(posedge clk);
        #1;
    endtask

    vec_t vecs[13];

    initial begin
        int n_ok;
        int err_drive;
        int t;
        int u;
        int rise;
        int v_before;
        logic got;

        vecs[0]  = '{G3, G4, 4'd4, 4'd3, 1'b1, 1'b1};
        vecs[1]  = '{G3, G4, 4'd4, 4'd3, 1'b0, 1'b1};
        vecs[2]  = '{G3, G4, 4'd4, 4'd3, 1'b0, 1'b1};
        vecs[3]  = '{G9, G4, 4'd4, 4'd9, 1'b1, 1'b1};
        vecs[4]  = '{G9, G4, 4'd4, 4'd9, 1'b0, 1'b1};
        vecs[5]  = '{GX, G4, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[6]  = '{G9, G4, 4'd4, 4'd9, 1'b0, 1'b1};
        vecs[7]  = '{G0, G0, 4'd0, 4'd0, 1'b1, 1'b1};
        vecs[8]  = '{G7, G8, 4'd8, 4'd7, 1'b1, 1'b1};
        vecs[9]  = '{G5, G2, 4'd2, 4'd5, 1'b1, 1'b1};
        vecs[10] = '{G6, G1, 4'd1, 4'd6, 1'b1, 1'b1};
        vecs[11] = '{G2, GB, 4'd0, 4'd0, 1'b0, 1'b0};
        vecs[12] = '{G8, G9, 4'd9, 4'd8, 1'b1, 1'b1};

        // Reset with random pins: every output held at zero.
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            seg1 = 7'($urandom);
            dig1 = 1'($urandom);
            seg2 = 7'($urandom);
            dig2 = 1'($urandom);
            @(negedge clk);
        end
        check("rst_ten", 32'(if1.ten_count), 32'd0);
        check("rst_unit", 32'(if1.unit_count), 32'd0);
        check("rst_valid", 32'(if1.valid), 32'd0);
        check("rst_changed", 32'(if1.changed), 32'd0);
        check("rst_code_error", 32'(if1.code_error), 32'd0);
        check("rst_stalled", 32'(if1.stalled), 32'd0);
        check("rst_dut2", 32'({if2.ten_count, if2.unit_count, if2.valid, if2.stalled}), 32'd0);

        seg1 = '0; dig1 = 1'b0; seg2 = '0; dig2 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("idle_no_valid1", 32'(v1_cnt), 32'd0);
        check("idle_no_valid2", 32'(v2_cnt), 32'd0);

        // Table: units/tens alternating every cycle.
        e1_cnt = 0;
        v1_cnt = 0;
        n_ok = 0;
        err_drive = 0;
        foreach (vecs[i]) begin
            if (vecs[i].u_seg == GX) err_drive = cyc;
            d1(vecs[i].u_seg, 1'b0);
            if (vecs[i].ok) begin
                q1.push_back('{vecs[i].ten, vecs[i].unit, vecs[i].chg});
                n_ok++;
            end else if (vecs[i].t_seg == GB) begin
                err_drive = cyc;
            end
            d1(vecs[i].t_seg, 1'b1);
        end
        repeat (6) @(posedge clk);
        #1;
        check("table_drain", 32'(q1.size()), 32'd0);
        check("table_valid_count", 32'(v1_cnt), 32'(n_ok));
        check("table_code_errors", 32'(e1_cnt), 32'd2);
        check("code_error_timing", 32'(e1_cyc), 32'(err_drive + 3));

        // STABLE_CYCLES=3: two-cycle glyphs never accepted, three-cycle frame publishes.
        for (int i = 0; i < 4; i++) begin
            d2(G3, 1'b0, 2);
            d2(G4, 1'b1, 2);
        end
        check("stable_short_no_valid", 32'(v2_cnt), 32'd0);
        d2(G9, 1'b0, 3);
        t = cyc;
        seg2 = G4;
        dig2 = 1'b1;
        got = 1'b0;
        rise = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!got && if2.valid) begin
                got = 1'b1;
                rise = cyc;
                check("stable_pair", 32'({if2.ten_count, if2.unit_count, if2.changed}),
                      32'({4'd4, 4'd9, 1'b1}));
            end
        end
        check("stable_valid_seen", 32'(got), 32'd1);
        check("stable_latency", 32'(rise), 32'(t + 5));

        // Stall: freeze on tens after a full frame.
        @(posedge clk);
        #1;
        d1(G3, 1'b0);
        t = cyc;
        q1.push_back('{4'd4, 4'd3, 1'b1});
        seg1 = G4;
        dig1 = 1'b1;
        got = 1'b0;
        rise = 0;
        for (int i = 0; i < 1200; i++) begin
            @(negedge clk);
            if (!got && cyc >= t + 3 && if1.stalled) begin
                got = 1'b1;
                rise = cyc;
            end
        end
        check("stall_seen", 32'(got), 32'd1);
        check("stall_rise_cycle", 32'(rise), 32'(t + 1027));
        check("stall_holds_pair", 32'({if1.ten_count, if1.unit_count}), 32'({4'd4, 4'd3}));

        @(posedge clk);
        #1;
        u = cyc;
        seg1 = G2;
        dig1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("stall_before_clear", 32'(if1.stalled), 32'd1);
        @(negedge clk);
        check("stall_cleared", 32'(if1.stalled), 32'd0);
        check("stall_clear_cycle", 32'(cyc), 32'(u + 3));

        // Mid-frame reset after the units glyph was latched.
        @(posedge clk);
        #1;
        v_before = v1_cnt;
        seg1 = G5;
        dig1 = 1'b1;
        rst_n = 1'b0;
        #2;
        check("midrst_outputs",
              32'({if1.ten_count, if1.unit_count, if1.valid, if1.changed, if1.code_error, if1.stalled}),
              32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_publish", 32'(v1_cnt), 32'(v_before));
        d1(G2, 1'b0);
        q1.push_back('{4'd5, 4'd2, 1'b1});
        d1(G5, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check("final_drain", 32'(q1.size()), 32'd0);
        check("final_pair", 32'({if1.ten_count, if1.unit_count}), 32'({4'd5, 4'd2}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
